fp_execute_stage5: RTL and testbench
====================================

Name: fp_execute_stage5

Overview:
Final stage of the floating-point pipeline. It consumes the stage-4 outputs: the add/sub significand with its precomputed normalization shift, the raw multiplier product, and the special-case flags. Per lane it normalizes, rounds to nearest even, packs IEEE-754 single-precision results (or the FTOI integer), and registers them for writeback with a fixed latency of one cycle.

Parameters:
NUM_VECTOR_LANES, 16, number of independent lanes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fx4_instruction_valid  in  1  stage-4 slot valid
fx4_instruction  in  decoded_instruction_t  decoded op (alu_op used)
fx4_mask_value  in  vector_mask_t  lane mask
fx4_thread_idx  in  local_thread_idx_t  thread
fx4_subcycle  in  subcycle_t  subcycle
fx4_result_inf  in  NUM_VECTOR_LANES  force infinity
fx4_result_nan  in  NUM_VECTOR_LANES  force NaN
fx4_add_significand  in  NUM_VECTOR_LANESx32  unnormalized add/sub/ftoi significand
fx4_add_exponent  in  NUM_VECTOR_LANESx8  add exponent (leading one at bit 23)
fx4_add_result_sign  in  NUM_VECTOR_LANES  add/ftoi sign
fx4_logical_subtract  in  NUM_VECTOR_LANES  effective subtraction
fx4_norm_shift  in  NUM_VECTOR_LANESx6  left shift 0..32
fx4_significand_product  in  NUM_VECTOR_LANESx64  24x24 product
fx4_mul_exponent  in  NUM_VECTOR_LANESx8  biased product exponent
fx4_mul_underflow  in  NUM_VECTOR_LANES  product underflow
fx4_mul_sign  in  NUM_VECTOR_LANES  product sign
fx5_instruction_valid  out  1  result valid
fx5_instruction  out  decoded_instruction_t  passthrough
fx5_mask_value  out  vector_mask_t  passthrough
fx5_thread_idx  out  local_thread_idx_t  passthrough
fx5_subcycle  out  subcycle_t  passthrough
fx5_result  out  NUM_VECTOR_LANESx32  packed per-lane result

Behaviour:
- Reset: fx5_instruction_valid is cleared asynchronously to 0. All other outputs are unreset data registers and are don't-care until first loaded.
- Latency: exactly 1 cycle for every op. No stall, no backpressure. Every input is registered every cycle regardless of valid. All lanes are computed regardless of mask; the mask is passed through unchanged.
- Add path (OP_FADD, OP_FSUB, OP_ITOF), per lane:
  - n = add_significand << norm_shift, 32 bit.
  - mant = n[30:8]; guard = n[7]; sticky = |n[6:0].
  - exp = add_exponent + 8 - norm_shift, computed signed in 10 bits.
  - Round-to-nearest-even: round_up = guard & (sticky | mant[0]).
  - A mant carry-out sets mant = 0 and increments exp.
- Mul path (OP_FMUL), per lane:
  - If product[47]=1: mant = product[46:24], guard = product[23], sticky = |product[22:0], exp = mul_exponent + 1.
  - Otherwise: mant = product[45:23], guard = product[22], sticky = |product[21:0], exp = mul_exponent.
  - Rounding is identical to the add path.
- Packing priority, highest first:
  - nan: 0x7FFFFFFF.
  - inf: {sign, 0xFF, 0}.
  - add path with norm_shift == 32 (zero sum): 0x00000000 if logical_subtract, otherwise {sign, 31'b0}.
  - mul_underflow, or exp <= 0 after rounding: {sign, 31'b0} (denormals flushed).
  - exp >= 255 after rounding: {sign, 0xFF, 0} (infinity).
  - Otherwise: {sign, exp[7:0], mant}.
- Sign source: add_result_sign for the add path, mul_sign for the mul path.
- OP_FTOI: v = add_significand << norm_shift; result = add_result_sign ? -v : v (two's complement, 32 bit). nan or inf on FTOI: 0x80000000.
- Any other alu_op: fx5_result = 0, while valid and metadata still propagate.
- Reset asserted mid-stream: valid drops the same instant. The first valid after release is the registered fx4_instruction_valid of the first post-reset clock edge.

Test Plan:
- FADD, add_significand=0x01800000, norm_shift=7, add_exponent=127, sign=0 -> next cycle fx5_result=0x40400000, fx5_instruction_valid=1.
- Tie-to-even: significand=0x80000180, shift=0, exponent=127 -> 0x43800002; significand=0x80000080 -> 0x43800000.
- FMUL, product=0x0000C00000000000, mul_exponent=127, mul_sign=0 -> 0x40400000; same with product=0x0000600000000000 -> 0x3FC00000.
- Specials:
  - result_nan=1 -> 0x7FFFFFFF.
  - FMUL result_inf=1, mul_sign=1 -> 0xFF800000.
  - FADD shift=32, logical_subtract=1 -> 0x00000000.
  - add_exponent=247, significand=0x80000000, shift=0 -> 0x7F800000.
  - mul_underflow=1, mul_sign=1 -> 0x80000000.
- FTOI: significand=0x00000005, shift=4, sign=1 -> 0xFFFFFFB0; result_nan=1 -> 0x80000000.
- Valid stream 1,1,0,1 with reset pulsed asynchronously during the second cycle -> fx5_instruction_valid falls immediately on reset, stays 0 while reset is held, then follows the input with 1-cycle delay; per-lane results are independent across 16 lanes with distinct stimulus.

Source files
------------

// File: rtl/fp_execute_stage5.sv
// Final floating-point execute stage: normalize, round-to-nearest-even and pack
// single-precision (or FTOI integer) results per lane, registered for writeback.

package fp_execute_stage5_pkg;
    localparam int NUM_VECTOR_LANES = 16;

    typedef enum logic [5:0] {
        OP_OR   = 6'h00,
        OP_AND  = 6'h01,
        OP_XOR  = 6'h03,
        OP_ADDI = 6'h05,
        OP_FTOI = 6'h1b,
        OP_FADD = 6'h20,
        OP_FSUB = 6'h21,
        OP_FMUL = 6'h22,
        OP_ITOF = 6'h2a
    } alu_op_t;

    typedef struct packed {
        logic        has_dest;
        logic        dest_is_vector;
        logic [4:0]  dest_reg;
        alu_op_t     alu_op;
    } decoded_instruction_t;

    typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;
    typedef logic [1:0]                  local_thread_idx_t;
    typedef logic [3:0]                  subcycle_t;
endpackage

module fp_execute_stage5
    import fp_execute_stage5_pkg::*;
#(
    parameter int NUM_VECTOR_LANES = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fx4_instruction_valid,
    input  decoded_instruction_t                 fx4_instruction,
    input  vector_mask_t                         fx4_mask_value,
    input  local_thread_idx_t                    fx4_thread_idx,
    input  subcycle_t                            fx4_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_result_inf,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_result_nan,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]    fx4_add_significand,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]     fx4_add_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_logical_subtract,
    input  logic [NUM_VECTOR_LANES-1:0][5:0]     fx4_norm_shift,
    input  logic [NUM_VECTOR_LANES-1:0][63:0]    fx4_significand_product,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]     fx4_mul_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_mul_underflow,
    input  logic [NUM_VECTOR_LANES-1:0]          fx4_mul_sign,
    output logic                                 fx5_instruction_valid,
    output decoded_instruction_t                 fx5_instruction,
    output vector_mask_t                         fx5_mask_value,
    output local_thread_idx_t                    fx5_thread_idx,
    output subcycle_t                            fx5_subcycle,
    output logic [NUM_VECTOR_LANES-1:0][31:0]    fx5_result
);

    logic is_add;
    logic is_mul;
    logic is_ftoi;
    logic [NUM_VECTOR_LANES-1:0][31:0] result_next;

    assign is_add  = (fx4_instruction.alu_op == OP_FADD) || (fx4_instruction.alu_op == OP_FSUB)
                  || (fx4_instruction.alu_op == OP_ITOF);
    assign is_mul  = (fx4_instruction.alu_op == OP_FMUL);
    assign is_ftoi = (fx4_instruction.alu_op == OP_FTOI);

    for (genvar lane = 0; lane < NUM_VECTOR_LANES; lane++) begin : g_lane
        logic [31:0]       norm;
        logic [31:0]       ftoi_value;
        logic [22:0]       mant_raw;
        logic [22:0]       mant_final;
        logic [23:0]       mant_sum;
        logic              guard;
        logic              sticky;
        logic              round_up;
        logic              sign;
        logic signed [9:0] exp_raw;
        logic signed [9:0] exp_rnd;
        logic [31:0]       lane_result;
        logic              unused_product_high;

        // A 24x24 product never reaches above bit 47.
        assign unused_product_high = ^fx4_significand_product[lane][63:48];

        assign norm       = fx4_add_significand[lane] << fx4_norm_shift[lane];
        assign ftoi_value = fx4_add_result_sign[lane] ? (32'd0 - norm) : norm;

        always_comb begin
            sign     = fx4_add_result_sign[lane];
            mant_raw = norm[30:8];
            guard    = norm[7];
            sticky   = |norm[6:0];
            exp_raw  = $signed({2'b00, fx4_add_exponent[lane]}) + 10'sd8
                     - $signed({4'b0000, fx4_norm_shift[lane]});

            if (is_mul) begin
                sign = fx4_mul_sign[lane];
                if (fx4_significand_product[lane][47]) begin
                    mant_raw = fx4_significand_product[lane][46:24];
                    guard    = fx4_significand_product[lane][23];
                    sticky   = |fx4_significand_product[lane][22:0];
                    exp_raw  = $signed({2'b00, fx4_mul_exponent[lane]}) + 10'sd1;
                end else begin
                    mant_raw = fx4_significand_product[lane][45:23];
                    guard    = fx4_significand_product[lane][22];
                    sticky   = |fx4_significand_product[lane][21:0];
                    exp_raw  = $signed({2'b00, fx4_mul_exponent[lane]});
                end
            end

            round_up   = guard & (sticky | mant_raw[0]);
            mant_sum   = {1'b0, mant_raw} + {23'd0, round_up};
            mant_final = mant_sum[23] ? 23'd0 : mant_sum[22:0];
            exp_rnd    = exp_raw + (mant_sum[23] ? 10'sd1 : 10'sd0);

            lane_result = 32'd0;
            if (is_ftoi) begin
                lane_result = (fx4_result_nan[lane] || fx4_result_inf[lane]) ? 32'h8000_0000
                                                                             : ftoi_value;
            end else if (is_add || is_mul) begin
                if (fx4_result_nan[lane])
                    lane_result = 32'h7FFF_FFFF;
                else if (fx4_result_inf[lane])
                    lane_result = {sign, 8'hFF, 23'd0};
                else if (is_add && fx4_norm_shift[lane] == 6'd32)
                    // Exact cancellation gives +0; adding two zeros keeps their sign.
                    lane_result = fx4_logical_subtract[lane] ? 32'd0 : {sign, 31'd0};
                else if ((is_mul && fx4_mul_underflow[lane]) || exp_rnd <= 10'sd0)
                    lane_result = {sign, 31'd0};
                else if (exp_rnd >= 10'sd255)
                    lane_result = {sign, 8'hFF, 23'd0};
                else
                    lane_result = {sign, exp_rnd[7:0], mant_final};
            end
        end

        assign result_next[lane] = lane_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fx5_instruction_valid <= 1'b0;
        else
            fx5_instruction_valid <= fx4_instruction_valid;
    end

    always_ff @(posedge clk) begin
        fx5_instruction <= fx4_instruction;
        fx5_mask_value  <= fx4_mask_value;
        fx5_thread_idx  <= fx4_thread_idx;
        fx5_subcycle    <= fx4_subcycle;
        fx5_result      <= result_next;
    end

endmodule

// File: tb/tb_fp_execute_stage5.sv
// Directed bench for fp_execute_stage5: packing, rounding, specials, FTOI,
// per-lane independence and asynchronous reset of the valid bit.

module tb_fp_execute_stage5;
    import fp_execute_stage5_pkg::*;

    localparam int LANES = 16;

    logic                          clk;
    logic                          reset;
    logic                          fx4_instruction_valid;
    decoded_instruction_t          fx4_instruction;
    vector_mask_t                  fx4_mask_value;
    local_thread_idx_t             fx4_thread_idx;
    subcycle_t                     fx4_subcycle;
    logic [LANES-1:0]              fx4_result_inf;
    logic [LANES-1:0]              fx4_result_nan;
    logic [LANES-1:0][31:0]        fx4_add_significand;
    logic [LANES-1:0][7:0]         fx4_add_exponent;
    logic [LANES-1:0]              fx4_add_result_sign;
    logic [LANES-1:0]              fx4_logical_subtract;
    logic [LANES-1:0][5:0]         fx4_norm_shift;
    logic [LANES-1:0][63:0]        fx4_significand_product;
    logic [LANES-1:0][7:0]         fx4_mul_exponent;
    logic [LANES-1:0]              fx4_mul_underflow;
    logic [LANES-1:0]              fx4_mul_sign;
    logic                          fx5_instruction_valid;
    decoded_instruction_t          fx5_instruction;
    vector_mask_t                  fx5_mask_value;
    local_thread_idx_t             fx5_thread_idx;
    subcycle_t                     fx5_subcycle;
    logic [LANES-1:0][31:0]        fx5_result;

    int n_compared;
    int n_mismatched;

    fp_execute_stage5 #(.NUM_VECTOR_LANES(LANES)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .fx4_instruction_valid   (fx4_instruction_valid),
        .fx4_instruction         (fx4_instruction),
        .fx4_mask_value          (fx4_mask_value),
        .fx4_thread_idx          (fx4_thread_idx),
        .fx4_subcycle            (fx4_subcycle),
        .fx4_result_inf          (fx4_result_inf),
        .fx4_result_nan          (fx4_result_nan),
        .fx4_add_significand     (fx4_add_significand),
        .fx4_add_exponent        (fx4_add_exponent),
        .fx4_add_result_sign     (fx4_add_result_sign),
        .fx4_logical_subtract    (fx4_logical_subtract),
        .fx4_norm_shift          (fx4_norm_shift),
        .fx4_significand_product (fx4_significand_product),
        .fx4_mul_exponent        (fx4_mul_exponent),
        .fx4_mul_underflow       (fx4_mul_underflow),
        .fx4_mul_sign            (fx4_mul_sign),
        .fx5_instruction_valid   (fx5_instruction_valid),
        .fx5_instruction         (fx5_instruction),
        .fx5_mask_value          (fx5_mask_value),
        .fx5_thread_idx          (fx5_thread_idx),
        .fx5_subcycle            (fx5_subcycle),
        .fx5_result              (fx5_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs(input alu_op_t op);
        fx4_instruction_valid   = 1'b1;
        fx4_instruction         = '0;
        fx4_instruction.alu_op  = op;
        fx4_mask_value          = '1;
        fx4_thread_idx          = '0;
        fx4_subcycle            = '0;
        fx4_result_inf          = '0;
        fx4_result_nan          = '0;
        fx4_add_significand     = '0;
        fx4_add_exponent        = '0;
        fx4_add_result_sign     = '0;
        fx4_logical_subtract    = '0;
        fx4_norm_shift          = '0;
        fx4_significand_product = '0;
        fx4_mul_exponent        = '0;
        fx4_mul_underflow       = '0;
        fx4_mul_sign            = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs(OP_FADD);
        #1;
        n_compared++;
        if (fx5_instruction_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_valid: got %b want 0", fx5_instruction_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fadd();
        clear_inputs(OP_FADD);
        fx4_add_significand[0] = 32'h0180_0000;
        fx4_norm_shift[0]      = 6'd7;
        fx4_add_exponent[0]    = 8'd127;
        step();
        n_compared++;
        if (fx5_result[0] !== 32'h4040_0000) begin
            n_mismatched++;
            $display("FAIL fadd_3p0: got %h want 40400000", fx5_result[0]);
        end
        n_compared++;
        if (fx5_instruction_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL fadd_valid: got %b want 1", fx5_instruction_valid);
        end
    endtask

    task automatic test_round_even();
        logic [31:0] sig [3]  = '{32'h8000_0180, 32'h8000_0080, 32'hFFFF_FF80};
        logic [31:0] want [3] = '{32'h4380_0002, 32'h4380_0000, 32'h4400_0000};
        for (int i = 0; i < 3; i++) begin
            clear_inputs(OP_FSUB);
            fx4_add_significand[0] = sig[i];
            fx4_add_exponent[0]    = 8'd127;
            step();
            n_compared++;
            if (fx5_result[0] !== want[i]) begin
                n_mismatched++;
                $display("FAIL round_even[%0d]: got %h want %h", i, fx5_result[0], want[i]);
            end
        end
    endtask

    task automatic test_fmul();
        logic [63:0] prod [2] = '{64'h0000_C000_0000_0000, 64'h0000_6000_0000_0000};
        logic [31:0] want [2] = '{32'h4040_0000, 32'h3FC0_0000};
        for (int i = 0; i < 2; i++) begin
            clear_inputs(OP_FMUL);
            fx4_significand_product[0] = prod[i];
            fx4_mul_exponent[0]        = 8'd127;
            step();
            n_compared++;
            if (fx5_result[0] !== want[i]) begin
                n_mismatched++;
                $display("FAIL fmul[%0d]: got %h want %h", i, fx5_result[0], want[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] want [9] = '{32'h7FFF_FFFF, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000,
                                  32'h7F80_0000, 32'h7F00_0000, 32'h8000_0000, 32'h8000_0000,
                                  32'h8080_0000};
        for (int i = 0; i < 9; i++) begin
            clear_inputs(OP_FADD);
            fx4_add_significand[0] = 32'h8000_0000;
            fx4_add_exponent[0]    = 8'd127;
            case (i)
                0: fx4_result_nan[0] = 1'b1;
                1: begin
                    fx4_instruction.alu_op = OP_FMUL;
                    fx4_result_inf[0] = 1'b1;
                    fx4_mul_sign[0]   = 1'b1;
                end
                2: begin
                    fx4_norm_shift[0]       = 6'd32;
                    fx4_logical_subtract[0] = 1'b1;
                    fx4_add_result_sign[0]  = 1'b1;
                end
                3: begin
                    fx4_norm_shift[0]      = 6'd32;
                    fx4_add_result_sign[0] = 1'b1;
                end
                4: fx4_add_exponent[0] = 8'd247;
                5: fx4_add_exponent[0] = 8'd246;
                6: begin
                    fx4_instruction.alu_op = OP_FMUL;
                    fx4_significand_product[0] = 64'h0000_C000_0000_0000;
                    fx4_mul_exponent[0]  = 8'd127;
                    fx4_mul_underflow[0] = 1'b1;
                    fx4_mul_sign[0]      = 1'b1;
                end
                7: begin
                    fx4_add_significand[0] = 32'h0080_0000;
                    fx4_norm_shift[0]      = 6'd8;
                    fx4_add_exponent[0]    = 8'd0;
                    fx4_add_result_sign[0] = 1'b1;
                end
                default: begin
                    fx4_add_significand[0] = 32'h0080_0000;
                    fx4_norm_shift[0]      = 6'd8;
                    fx4_add_exponent[0]    = 8'd1;
                    fx4_add_result_sign[0] = 1'b1;
                end
            endcase
            step();
            n_compared++;
            if (fx5_result[0] !== want[i]) begin
                n_mismatched++;
                $display("FAIL special[%0d]: got %h want %h", i, fx5_result[0], want[i]);
            end
        end
    endtask

    task automatic test_ftoi();
        clear_inputs(OP_FTOI);
        fx4_add_significand[0] = 32'h0000_0005;
        fx4_norm_shift[0]      = 6'd4;
        fx4_add_result_sign[0] = 1'b1;
        fx4_add_significand[1] = 32'h0000_0005;
        fx4_norm_shift[1]      = 6'd4;
        fx4_result_nan[1]      = 1'b1;
        fx4_add_significand[2] = 32'h0000_0123;
        fx4_norm_shift[2]      = 6'd8;
        step();
        n_compared++;
        if (fx5_result[0] !== 32'hFFFF_FFB0) begin
            n_mismatched++;
            $display("FAIL ftoi_neg: got %h want ffffffb0", fx5_result[0]);
        end
        n_compared++;
        if (fx5_result[1] !== 32'h8000_0000) begin
            n_mismatched++;
            $display("FAIL ftoi_nan: got %h want 80000000", fx5_result[1]);
        end
        n_compared++;
        if (fx5_result[2] !== 32'h0001_2300) begin
            n_mismatched++;
            $display("FAIL ftoi_pos: got %h want 00012300", fx5_result[2]);
        end
    endtask

    task automatic test_other_op();
        decoded_instruction_t want_instr;
        clear_inputs(OP_AND);
        fx4_instruction.dest_reg = 5'd19;
        fx4_instruction.has_dest = 1'b1;
        fx4_mask_value           = 16'hA5C3;
        fx4_thread_idx           = 2'd2;
        fx4_subcycle             = 4'd9;
        fx4_add_significand[0]   = 32'h0180_0000;
        fx4_norm_shift[0]        = 6'd7;
        fx4_add_exponent[0]      = 8'd127;
        want_instr               = '0;
        want_instr.alu_op        = OP_AND;
        want_instr.dest_reg      = 5'd19;
        want_instr.has_dest      = 1'b1;
        step();
        n_compared++;
        if (fx5_result[0] !== 32'd0) begin
            n_mismatched++;
            $display("FAIL other_op_result: got %h want 00000000", fx5_result[0]);
        end
        n_compared++;
        if (fx5_instruction !== want_instr || fx5_mask_value !== 16'hA5C3
            || fx5_thread_idx !== 2'd2 || fx5_subcycle !== 4'd9) begin
            n_mismatched++;
            $display("FAIL passthrough: got %h/%h/%0d/%0d want %h/a5c3/2/9",
                     fx5_instruction, fx5_mask_value, fx5_thread_idx, fx5_subcycle, want_instr);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] want;
        logic [7:0]  exp_want;
        clear_inputs(OP_FADD);
        fx4_mask_value = 16'h0001;
        for (int i = 0; i < LANES; i++) begin
            fx4_add_significand[i] = 32'h0180_0000;
            fx4_norm_shift[i]      = 6'd7;
            fx4_add_exponent[i]    = 8'(100 + i);
            fx4_add_result_sign[i] = 1'(i % 2);
        end
        step();
        for (int i = 0; i < LANES; i++) begin
            exp_want = 8'(101 + i);
            want     = {1'(i % 2), exp_want, 23'h40_0000};
            n_compared++;
            if (fx5_result[i] !== want) begin
                n_mismatched++;
                $display("FAIL lane[%0d]: got %h want %h", i, fx5_result[i], want);
            end
        end
    endtask

    task automatic test_valid_stream();
        logic want [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic got  [5];
        clear_inputs(OP_FADD);
        fx4_instruction_valid = 1'b1;
        step();
        got[0] = fx5_instruction_valid;
        fx4_instruction_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        got[1] = fx5_instruction_valid;
        step();
        got[2] = fx5_instruction_valid;
        @(negedge clk);
        reset = 1'b0;
        fx4_instruction_valid = 1'b0;
        step();
        got[3] = fx5_instruction_valid;
        fx4_instruction_valid = 1'b1;
        step();
        got[4] = fx5_instruction_valid;
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (got[i] !== want[i]) begin
                n_mismatched++;
                $display("FAIL valid_stream[%0d]: got %b want %b", i, got[i], want[i]);
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_fadd();
        test_round_even();
        test_fmul();
        test_specials();
        test_ftoi();
        test_other_op();
        test_lanes();
        test_valid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
